// File: rtl/ysyx_25040109_dmem_if.sv
// LSU-to-data-memory bus: level-held read/write requests and single-cycle completion pulses.
interface ysyx_25040109_dmem_if;
  logic        dmem_ren;
  logic [31:0] dmem_raddr;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        dmem_wen;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [2:0]  dmem_wlen;
  logic        dmem_wready;
  logic        dmem_err;

  modport master (
    output dmem_ren, dmem_raddr, dmem_wen, dmem_waddr, dmem_wdata, dmem_wlen,
    input  dmem_rdata, dmem_rvalid, dmem_wready, dmem_err
  );

  modport slave (
    input  dmem_ren, dmem_raddr, dmem_wen, dmem_waddr, dmem_wdata, dmem_wlen,
    output dmem_rdata, dmem_rvalid, dmem_wready, dmem_err
  );
endinterface

// File: rtl/ysyx_25040109_dmem.sv
// Word-organised data memory slave with byte-lane write merging, right-aligned reads,
// fixed or LFSR-driven response latency and a sticky access-fault flag.
//
// state | meaning
// IDLE  | waiting for a request; write has priority over read
// BUSY  | latency counter running, request inputs ignored
// RESP  | one-cycle rvalid/wready pulse; memory write commits on leaving
module ysyx_25040109_dmem #(
  parameter int          DEPTH_W  = 12,
  parameter logic [31:0] BASE     = 32'h8000_0000,
  parameter int          LATENCY  = 1,
  parameter bit          RAND_LAT = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_25040109_dmem_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t       state;
  logic [7:0]   cnt;
  logic [7:0]   lfsr;
  logic [31:0]  addr_q;
  logic [31:0]  data_q;
  logic [2:0]   wlen_q;
  logic         is_wr_q;
  logic         fault_q;

  logic [31:0]  mem [0:(1<<DEPTH_W)-1];

  logic         accept;
  logic [31:0]  req_addr;
  logic [31:0]  req_off;
  logic         req_fault;
  logic         wlen_ok;
  logic         misaligned;
  logic [7:0]   lat_m1;
  logic [7:0]   lfsr_next;

  logic [31:0]        resp_off;
  logic [DEPTH_W-1:0] resp_idx;
  logic               resp_wr;
  logic               resp_fault;
  logic               enter_resp;
  logic [3:0]         wmask;
  logic [31:0]        wrep;
  logic               commit;

  assign accept    = (state == IDLE) && (bus.dmem_wen || bus.dmem_ren);
  assign req_addr  = bus.dmem_wen ? bus.dmem_waddr : bus.dmem_raddr;
  assign req_off   = req_addr - BASE;
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign lat_m1    = RAND_LAT ? {6'd0, lfsr[1:0]} : 8'(LATENCY - 1);

  always_comb begin
    wlen_ok    = 1'b0;
    misaligned = 1'b0;
    case (bus.dmem_wlen)
      3'b001: wlen_ok = 1'b1;
      3'b010: begin wlen_ok = 1'b1; misaligned = req_off[0]; end
      3'b100: begin wlen_ok = 1'b1; misaligned = (req_off[1:0] != 2'b00); end
      default: wlen_ok = 1'b0;
    endcase
  end

  // Size/alignment rules only apply to writes; reads are checked for range alone.
  assign req_fault = (req_off[31:DEPTH_W+2] != '0) ||
                     (bus.dmem_wen && (!wlen_ok || misaligned));

  // The access reaching RESP is either the one being accepted now or the latched one.
  assign resp_off   = ((state == IDLE) ? req_addr : addr_q) - BASE;
  assign resp_idx   = resp_off[DEPTH_W+1:2];
  assign resp_wr    = (state == IDLE) ? bus.dmem_wen : is_wr_q;
  assign resp_fault = (state == IDLE) ? req_fault : fault_q;
  assign enter_resp = (accept && (lat_m1 == 8'd0)) || ((state == BUSY) && (cnt == 8'd1));

  always_comb begin
    wmask = 4'b0000;
    wrep  = data_q;
    case (wlen_q)
      3'b001: begin wmask = 4'b0001 << resp_off[1:0]; wrep = {4{data_q[7:0]}}; end
      3'b010: begin wmask = resp_off[1] ? 4'b1100 : 4'b0011; wrep = {2{data_q[15:0]}}; end
      3'b100: wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
  end

  assign commit = (state == RESP) && is_wr_q && !fault_q && !rst;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (commit && wmask[i]) mem[resp_idx][8*i +: 8] <= wrep[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      lfsr            <= 8'h5A;
      addr_q          <= 32'd0;
      data_q          <= 32'd0;
      wlen_q          <= 3'd0;
      is_wr_q         <= 1'b0;
      fault_q         <= 1'b0;
      bus.dmem_rvalid <= 1'b0;
      bus.dmem_wready <= 1'b0;
      bus.dmem_rdata  <= 32'd0;
      bus.dmem_err    <= 1'b0;
    end else begin
      bus.dmem_rvalid <= 1'b0;
      bus.dmem_wready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            data_q  <= bus.dmem_wdata;
            wlen_q  <= bus.dmem_wlen;
            is_wr_q <= bus.dmem_wen;
            fault_q <= req_fault;
            cnt     <= lat_m1;
            if (RAND_LAT) lfsr <= lfsr_next;
            state   <= (lat_m1 == 8'd0) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        bus.dmem_rvalid <= !resp_wr;
        bus.dmem_wready <= resp_wr;
        if (!resp_wr) bus.dmem_rdata <= resp_fault ? 32'd0 : (mem[resp_idx] >> {resp_off[1:0], 3'b000});
        if (resp_fault) bus.dmem_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_dmem.sv
// Directed and randomized checks of two dmem instances: fixed latency 3 and LFSR latency.
module tb_ysyx_25040109_dmem;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] RB   = BASE + 32'h100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  ren, wen;
  logic [31:0] raddr [2];
  logic [31:0] waddr [2];
  logic [31:0] wdata [2];
  logic [2:0]  wlen  [2];
  logic [1:0]  rvalid, wready, err;
  logic [31:0] rdata [2];

  int errors = 0;
  int checks = 0;
  logic [7:0] lfsr_m;

  ysyx_25040109_dmem_if bf();
  ysyx_25040109_dmem_if br();

  assign bf.dmem_ren = ren[0];  assign bf.dmem_raddr = raddr[0];
  assign bf.dmem_wen = wen[0];  assign bf.dmem_waddr = waddr[0];
  assign bf.dmem_wdata = wdata[0]; assign bf.dmem_wlen = wlen[0];
  assign br.dmem_ren = ren[1];  assign br.dmem_raddr = raddr[1];
  assign br.dmem_wen = wen[1];  assign br.dmem_waddr = waddr[1];
  assign br.dmem_wdata = wdata[1]; assign br.dmem_wlen = wlen[1];
  assign rvalid = {br.dmem_rvalid, bf.dmem_rvalid};
  assign wready = {br.dmem_wready, bf.dmem_wready};
  assign err    = {br.dmem_err, bf.dmem_err};
  assign rdata[0] = bf.dmem_rdata;
  assign rdata[1] = br.dmem_rdata;

  ysyx_25040109_dmem #(.DEPTH_W(12), .BASE(BASE), .LATENCY(3), .RAND_LAT(1'b0)) dut_f (
    .clk(clk), .rst(rst), .bus(bf.slave));
  ysyx_25040109_dmem #(.DEPTH_W(12), .BASE(BASE), .LATENCY(1), .RAND_LAT(1'b1)) dut_r (
    .clk(clk), .rst(rst), .bus(br.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected latency of the next accept from the LFSR model, then step the model.
  task automatic next_lat(output int l);
    l = 1 + int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
  endtask

  task automatic wr(input int s, input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] len, output int lat);
    wen[s] = 1'b1; waddr[s] = a; wdata[s] = d; wlen[s] = len; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!wready[s] && lat < 20);
    wen[s] = 1'b0;
    @(posedge clk); #1;
    chk("wready_one_cycle", {31'd0, wready[s]}, 32'd0);
  endtask

  task automatic rd(input int s, input logic [31:0] a, output int lat, output logic [31:0] d);
    ren[s] = 1'b1; raddr[s] = a; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!rvalid[s] && lat < 20);
    d = rdata[s];
    ren[s] = 1'b0;
    @(posedge clk); #1;
    chk("rvalid_one_cycle", {31'd0, rvalid[s]}, 32'd0);
  endtask

  initial begin
    int lat, el, n, idx, off, nb;
    logic [31:0] d, v;
    logic [63:0] mask;
    logic [31:0] model [8];
    logic seen;

    rst = 1'b1; ren = '0; wen = '0;
    for (int s = 0; s < 2; s++) begin
      raddr[s] = '0; waddr[s] = '0; wdata[s] = '0; wlen[s] = 3'b100;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_rvalid", {31'd0, rvalid[s]}, 32'd0);
      chk("rst_wready", {31'd0, wready[s]}, 32'd0);
      chk("rst_rdata", rdata[s], 32'd0);
      chk("rst_err", {31'd0, err[s]}, 32'd0);
    end
    rst = 1'b0;

    // Fixed latency 3: preload then read back.
    wr(0, BASE, 32'hDEADBEEF, 3'b100, lat);        chk("sw0_lat", 32'(lat), 32'd3);
    rd(0, BASE, lat, d);                           chk("lw0_lat", 32'(lat), 32'd3);
    chk("lw0_data", d, 32'hDEADBEEF);

    // Lane merging and right alignment.
    wr(0, BASE + 8, 32'h11223344, 3'b100, lat);
    wr(0, BASE + 9, 32'h555555AA, 3'b001, lat);    chk("sb_lat", 32'(lat), 32'd3);
    rd(0, BASE + 8, lat, d);                       chk("lw8_merge", d, 32'h1122AA44);
    rd(0, BASE + 9, lat, d);                       chk("lb9", d, 32'h001122AA);
    rd(0, BASE + 10, lat, d);                      chk("lh10", d, 32'h00001122);
    wr(0, BASE + 12, 32'h55667788, 3'b100, lat);

    // Simultaneous write and read: write wins, read follows in the next IDLE cycle.
    wen[0] = 1'b1; waddr[0] = BASE + 4; wdata[0] = 32'hCAFEBABE; wlen[0] = 3'b100;
    ren[0] = 1'b1; raddr[0] = BASE + 4;
    n = 0; seen = 1'b0;
    do begin @(posedge clk); #1; n++; seen |= rvalid[0]; end while (!wready[0] && n < 20);
    chk("simul_wlat", 32'(n), 32'd3);
    chk("simul_no_early_rvalid", {31'd0, seen}, 32'd0);
    wen[0] = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rvalid[0] && n < 20);
    chk("simul_read_delay", 32'(n), 32'd4);
    chk("simul_read_data", rdata[0], 32'hCAFEBABE);
    ren[0] = 1'b0;
    @(posedge clk); #1;

    // Faults: out-of-range read, misaligned half, illegal wlen.
    chk("err_clear_before", {31'd0, err[0]}, 32'd0);
    rd(0, BASE - 4, lat, d);                       chk("oor_lat", 32'(lat), 32'd3);
    chk("oor_data", d, 32'd0);
    chk("oor_err", {31'd0, err[0]}, 32'd1);
    wr(0, BASE + 1, 32'h0000BEEF, 3'b010, lat);    chk("mis_sh_lat", 32'(lat), 32'd3);
    wr(0, BASE + 8, 32'hFFFFFFFF, 3'b011, lat);
    rd(0, BASE, lat, d);                           chk("mis_sh_nochange", d, 32'hDEADBEEF);
    rd(0, BASE + 8, lat, d);                       chk("bad_wlen_nochange", d, 32'h1122AA44);
    chk("err_sticky", {31'd0, err[0]}, 32'd1);

    // Reset while BUSY abandons the write.
    wen[0] = 1'b1; waddr[0] = BASE + 12; wdata[0] = 32'hFFFFFFFF; wlen[0] = 3'b100;
    @(posedge clk); #1;
    rst = 1'b1; wen[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_rvalid", {31'd0, rvalid[0]}, 32'd0);
    chk("mid_rst_wready", {31'd0, wready[0]}, 32'd0);
    chk("mid_rst_rdata", rdata[0], 32'd0);
    chk("mid_rst_err", {31'd0, err[0]}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; seen |= wready[0]; end
    chk("mid_rst_no_wready", {31'd0, seen}, 32'd0);
    rd(0, BASE + 12, lat, d);                      chk("mid_rst_word_kept", d, 32'h55667788);

    // Random latency instance against the LFSR and memory model (LFSR reseeded by the reset above).
    lfsr_m = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      next_lat(el);
      wr(1, RB + 32'(4 * i), d, 3'b100, lat);
      chk("rnd_sw_lat", 32'(lat), 32'(el));
      model[i] = d;
    end
    for (int k = 0; k < 12; k++) begin
      idx = $urandom_range(0, 7);
      nb  = 1 << $urandom_range(0, 2);
      off = $urandom_range(0, 3) & ~(nb - 1);
      d   = $urandom;
      next_lat(el);
      wr(1, RB + 32'(4 * idx + off), d, 3'(nb), lat);
      chk("rnd_sub_lat", 32'(lat), 32'(el));
      mask = ((64'd1 << (8 * nb)) - 64'd1) << (8 * off);
      model[idx] = (model[idx] & ~mask[31:0]) | ((d << (8 * off)) & mask[31:0]);
    end
    for (int k = 0; k < 16; k++) begin
      idx = $urandom_range(0, 7);
      off = $urandom_range(0, 3);
      next_lat(el);
      rd(1, RB + 32'(4 * idx + off), lat, v);
      chk("rnd_rd_lat", 32'(lat), 32'(el));
      chk("rnd_rd_data", v, model[idx] >> (8 * off));
    end
    chk("rnd_err", {31'd0, err[1]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_25040109_dmem.md
# ysyx_25040109_dmem

Word-organised data memory slave sitting directly downstream of the LSU dmem port. It accepts one read or write request at a time over level-held valid/ready handshakes and answers after a fixed or pseudo-random latency. It performs byte-lane merging for SB/SH/SW and right-aligns read data so the LSU's sign/zero extension of bits [7:0]/[15:0] is correct. It flags out-of-range and misaligned accesses.

## Interface
- DEPTH_W, 12: log2 of word count (4096 words, 16 KiB).
- BASE, 32'h8000_0000: byte address of word 0.
- LATENCY, 1: fixed response latency in cycles, ≥1; used when RAND_LAT=0.
- RAND_LAT, 0: 1 = latency 1..4 drawn from internal LFSR.

- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- dmem_ren  in  1  read request, held high until dmem_rvalid.
- dmem_raddr  in  32  read byte address.
- dmem_rdata  out  32  read data, right-aligned to bit 0.
- dmem_rvalid  out  1  one-cycle read response pulse.
- dmem_wen  in  1  write request, held high until dmem_wready.
- dmem_waddr  in  32  write byte address.
- dmem_wdata  in  32  write data, right-aligned (byte in [7:0], half in [15:0]).
- dmem_wlen  in  3  001 byte, 010 half, 100 word; other values illegal.
- dmem_wready  out  1  one-cycle write completion pulse.
- dmem_err  out  1  sticky access-fault flag.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if dmem_wen, accept write; else if dmem_ren, accept read. Write wins on simultaneous requests; read stays pending and is accepted in the next IDLE cycle. On accept: latch address, data, wlen, op type; load counter with latency−1; go BUSY (or RESP directly if latency=1).
- BUSY: decrement counter; at 0 go RESP. Request inputs ignored; latched copies are used even if ren/wen drop (request is not abortable).
- RESP: assert dmem_rvalid (read) or dmem_wready (write) for exactly one cycle; return to IDLE. The requester drops its request the cycle after the pulse, so no re-acceptance occurs.
- Write: on the RESP edge, update the lanes of word (addr−BASE)[DEPTH_W+1:2]: byte → lane addr[1:0] gets wdata[7:0]; half → lanes {addr[1],0}..+1 get wdata[15:0]; word → all lanes. Other lanes are unchanged.
- Read: dmem_rdata = word >> (8*addr[1:0]), zero-filled; held stable from RESP until the next read response.
- Fault: address outside [BASE, BASE+4·2^DEPTH_W), half with addr[0]=1, word with addr[1:0]≠0, or an illegal wlen → write dropped / read returns 0, dmem_err set. Handshake still completes normally. dmem_err clears only on rst.
- RAND_LAT: 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'h5A at reset, advances once per accept. Latency = 1 + lfsr[1:0], using the pre-advance value.

## Timing
- Reset values: state IDLE, dmem_rvalid=0, dmem_wready=0, dmem_rdata=0, dmem_err=0, counter 0, LFSR 8'h5A. Memory contents are not reset.
- Request seen in IDLE at cycle t → pulse in cycle t+L (L=latency); minimum L=1.
- Read-after-write: a read accepted after the write's RESP cycle returns the new data.
- Back-to-back: a new accept is possible the cycle after RESP; throughput is one access per L+1 cycles.
- rst mid-operation (BUSY/RESP): the access is abandoned, no pulse is emitted, no memory update occurs, and the block returns to IDLE next cycle.
- Outputs are registered; no combinational path from inputs to dmem_rvalid/dmem_wready.

## Test plan
- Reset, then hold ren with raddr=BASE+0 and LATENCY=3 → rvalid=0 for 2 cycles, one pulse in cycle t+3, rdata = preloaded word; rvalid low afterwards.
- SW 0x11223344 @BASE+8, then SB 0xAA @BASE+9, then LW @BASE+8 → 0x1122AA44; LB @BASE+9 → rdata[7:0]=0xAA; LH @BASE+10 → rdata=0x00001122.
- Simultaneous wen (SW 0xCAFEBABE @BASE+4) and ren @BASE+4 → wready pulses first; read is accepted next IDLE cycle and returns 0xCAFEBABE.
- Read @BASE−4 and SH @BASE+1 → each handshake completes, read returns 0, memory unchanged, dmem_err=1 and stays 1 until rst.
- Assert rst while BUSY on a write of 0xFFFFFFFF @BASE+12 → no wready, word unchanged, all outputs at reset values next cycle.
- RAND_LAT=1, 16 back-to-back reads → each latency is in 1..4 and matches the LFSR model from seed 8'h5A; data is correct every time.
